// File: rtl/post_neur_rmw_ctrl.sv
// Read-modify-write sequencer for the post-neuron state SRAM: ACC/READ take 2 cycles, SET 1, CLEAR_ALL 2^ADDR_WIDTH.
// REQ_READY is high in IDLE and in the final (WR) cycle of an op, so a held request is taken back-to-back.
module post_neur_rmw_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int LANE_W     = 16,
  localparam int DATA_WIDTH = LANES * LANE_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [1:0]            REQ_OP,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic [LANES-1:0]      RSP_SAT,
  output logic                  BUSY,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_DIN,
  input  logic [DATA_WIDTH-1:0] SRAM_DOUT
);

  typedef enum logic [1:0] {IDLE, RD, WR, SWEEP} state_t;

  localparam logic [1:0] OP_ACC  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [ADDR_WIDTH:0] SWEEP_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state;
  state_t                  first_state;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADDR_WIDTH:0]     sweep_cnt;
  logic [DATA_WIDTH-1:0]   acc_word;
  logic [LANES-1:0]        sat_vec;
  logic                    accept;

  assign REQ_READY = (state == IDLE) || (state == WR);
  assign BUSY      = (state != IDLE);
  assign accept    = REQ_VALID && REQ_READY;

  // Per-lane add at LANE_W+1 bits; overflow shows as the top two sum bits disagreeing.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a_l;
    logic [LANE_W-1:0] b_l;
    logic [LANE_W:0]   sum_l;
    assign a_l        = SRAM_DOUT[i*LANE_W +: LANE_W];
    assign b_l        = data_q[i*LANE_W +: LANE_W];
    assign sum_l      = {a_l[LANE_W-1], a_l} + {b_l[LANE_W-1], b_l};
    assign sat_vec[i] = sum_l[LANE_W] ^ sum_l[LANE_W-1];
    assign acc_word[i*LANE_W +: LANE_W] =
      !sat_vec[i]    ? sum_l[LANE_W-1:0] :
      sum_l[LANE_W]  ? {1'b1, {(LANE_W-1){1'b0}}} :
                       {1'b0, {(LANE_W-1){1'b1}}};
  end

  always_comb begin
    case (REQ_OP)
      OP_SET:  first_state = WR;
      OP_CLR:  first_state = SWEEP;
      default: first_state = RD;
    endcase
  end

  always_comb begin
    SRAM_CS   = 1'b0;
    SRAM_WE   = 1'b0;
    SRAM_ADDR = '0;
    SRAM_DIN  = '0;
    case (state)
      RD: begin
        SRAM_CS   = 1'b1;
        SRAM_ADDR = addr_q;
      end
      WR: begin
        if (op_q != OP_READ) begin
          SRAM_CS   = 1'b1;
          SRAM_WE   = 1'b1;
          SRAM_ADDR = addr_q;
          SRAM_DIN  = (op_q == OP_ACC) ? acc_word : data_q;
        end
      end
      SWEEP: begin
        SRAM_CS   = 1'b1;
        SRAM_WE   = 1'b1;
        SRAM_ADDR = sweep_cnt[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sweep_cnt <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_SAT   <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      if (accept) begin
        op_q      <= REQ_OP;
        addr_q    <= REQ_ADDR;
        data_q    <= REQ_DATA;
        sweep_cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (accept) state <= first_state;
        end
        RD: state <= WR;
        WR: begin
          // Response uses the outgoing op; a new request may be latched on the same edge.
          if (op_q == OP_ACC) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= acc_word;
            RSP_SAT   <= sat_vec;
          end else if (op_q == OP_READ) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= SRAM_DOUT;
            RSP_SAT   <= '0;
          end
          state <= accept ? first_state : IDLE;
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + CNT_ONE;
          if (sweep_cnt == SWEEP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_post_neur_rmw_ctrl.sv
// Bench for post_neur_rmw_ctrl: behavioural SRAM, occupancy/response model checked every cycle, directed plus random ops.
module tb_post_neur_rmw_ctrl;

  localparam int AW    = 8;
  localparam int LANES = 8;
  localparam int LW    = 16;
  localparam int DW    = LANES * LW;
  localparam int DEPTH = 1 << AW;
  localparam int MAXV  = (1 << (LW - 1)) - 1;
  localparam int MINV  = -(1 << (LW - 1));

  localparam logic [1:0] OP_ACC  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic          CLK;
  logic          RST_N;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [1:0]    REQ_OP;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_DATA;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic [LANES-1:0] RSP_SAT;
  logic          BUSY;
  logic          SRAM_CS;
  logic          SRAM_WE;
  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] SRAM_DIN;
  logic [DW-1:0] SRAM_DOUT;

  post_neur_rmw_ctrl #(.ADDR_WIDTH(AW), .LANES(LANES), .LANE_W(LW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_SAT(RSP_SAT),
    .BUSY(BUSY),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DIN(SRAM_DIN), .SRAM_DOUT(SRAM_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port SRAM, 1-cycle read latency, output holds when not reading.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge CLK) begin
    if (SRAM_CS) begin
      if (SRAM_WE) sram_mem[SRAM_ADDR] <= SRAM_DIN;
      else         SRAM_DOUT <= sram_mem[SRAM_ADDR];
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_timeout(input string nm);
    checks++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic logic [DW-1:0] rep(input logic [LW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic void acc_model(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                    output logic [DW-1:0] nw, output logic [LANES-1:0] s);
    for (int i = 0; i < LANES; i++) begin
      int a;
      int b;
      int sum;
      a = $signed(old[i*LW +: LW]);
      b = $signed(d[i*LW +: LW]);
      sum = a + b;
      s[i] = 1'b0;
      if (sum > MAXV) begin sum = MAXV; s[i] = 1'b1; end
      else if (sum < MINV) begin sum = MINV; s[i] = 1'b1; end
      nw[i*LW +: LW] = sum[LW-1:0];
    end
  endfunction

  // Reference model: memory image, cycles each accepted op occupies, and expected responses.
  typedef struct {
    logic [DW-1:0]    d;
    logic [LANES-1:0] s;
    int               due;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          exp_q[$];
  int            occ_left = 0;
  logic [1:0]    occ_op = 2'b00;
  logic [AW-1:0] occ_addr = '0;
  bit            sweep_on = 1'b0;
  int            sweep_idx = 0;
  int            edge_n = 0;
  bit            chk_en = 1'b0;
  int            rsp_seen = 0;
  int            last_rsp_edge = 0;
  logic [DW-1:0] last_dat = '0;
  logic [LANES-1:0] last_sat = '0;
  logic [DW-1:0] rsp_log[$];
  int            acc_log[$];

  always @(negedge CLK) begin
    bit exp_busy;
    bit exp_rdy;
    bit rsp_due;
    logic [DW-1:0] nw;
    logic [LANES-1:0] s;
    exp_busy = (occ_left > 0);
    exp_rdy  = (occ_left == 0) || (occ_left == 1 && occ_op != OP_CLR);
    if (chk_en) begin
      chk("busy", BUSY, exp_busy);
      chk("req_ready", REQ_READY, exp_rdy);
      if (!exp_busy) chk("sram_cs_idle", SRAM_CS, 1'b0);
      if (occ_left == 2 && (occ_op == OP_ACC || occ_op == OP_READ)) begin
        chk("rd_cs", SRAM_CS, 1'b1);
        chk("rd_we", SRAM_WE, 1'b0);
        chk("rd_addr", SRAM_ADDR, occ_addr);
      end
      if (sweep_on) begin
        chk("sweep_we", {SRAM_CS, SRAM_WE}, 2'b11);
        chk("sweep_addr", SRAM_ADDR, sweep_idx);
        chk("sweep_din", SRAM_DIN, '0);
      end
      rsp_due = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
      chk("rsp_valid", RSP_VALID, rsp_due);
      if (rsp_due) begin
        chk("rsp_data", RSP_DATA, exp_q[0].d);
        chk("rsp_sat", RSP_SAT, exp_q[0].s);
        void'(exp_q.pop_front());
      end
      if (RSP_VALID === 1'b1) begin
        rsp_seen++;
        rsp_log.push_back(RSP_DATA);
        last_rsp_edge = edge_n;
        last_dat = RSP_DATA;
        last_sat = RSP_SAT;
      end
    end
    // Advance the model across the coming rising edge.
    if (sweep_on) begin
      ref_mem[sweep_idx] = '0;
      sweep_idx++;
      if (sweep_idx == DEPTH) sweep_on = 1'b0;
    end
    if (occ_left > 0) occ_left--;
    if (!RST_N) begin
      occ_left = 0;
      sweep_on = 1'b0;
      exp_q.delete();
    end else if (REQ_VALID && exp_rdy) begin
      occ_op   = REQ_OP;
      occ_addr = REQ_ADDR;
      occ_left = (REQ_OP == OP_CLR) ? DEPTH : (REQ_OP == OP_SET) ? 1 : 2;
      acc_log.push_back(edge_n + 1);
      case (REQ_OP)
        OP_ACC: begin
          acc_model(ref_mem[REQ_ADDR], REQ_DATA, nw, s);
          ref_mem[REQ_ADDR] = nw;
          exp_q.push_back('{nw, s, edge_n + 3});
        end
        OP_SET:  ref_mem[REQ_ADDR] = REQ_DATA;
        OP_READ: exp_q.push_back('{ref_mem[REQ_ADDR], '0, edge_n + 3});
        default: begin sweep_on = 1'b1; sweep_idx = 0; end
      endcase
    end
    edge_n++;
  end

  // Present a request and return just after the edge that accepts it, REQ_VALID still high.
  task automatic issue(input logic [1:0] op, input int addr, input logic [DW-1:0] d);
    int t;
    REQ_OP    = op;
    REQ_ADDR  = addr[AW-1:0];
    REQ_DATA  = d;
    REQ_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!REQ_READY && t < 400) begin t++; @(negedge CLK); end
    if (t >= 400) chk_timeout("accept");
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic txn(input string nm, input logic [1:0] op, input int addr, input logic [DW-1:0] d,
                     input logic [DW-1:0] ed, input logic [LANES-1:0] es);
    int n0;
    int t;
    n0 = rsp_seen;
    issue(op, addr, d);
    REQ_VALID = 1'b0;
    t = 0;
    while (rsp_seen == n0 && t < 20) begin @(posedge CLK); #1; t++; end
    if (rsp_seen == n0) chk_timeout({nm, "_rsp"});
    else begin
      chk({nm, "_data"}, last_dat, ed);
      chk({nm, "_sat"}, last_sat, es);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    int n0;
    int a0;
    int busy_cnt;
    int rdy_bad;
    int bad;
    REQ_VALID = 1'b0;
    REQ_OP    = 2'b00;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
    RST_N     = 1'b0;
    SRAM_DOUT <= '0;
    for (int a = 0; a < DEPTH; a++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      sram_mem[a] <= w;
      ref_mem[a] = w;
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", REQ_READY, 1'b1);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_data", RSP_DATA, '0);
    chk("rst_rsp_sat", RSP_SAT, '0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_sram_cs", SRAM_CS, 1'b0);
    chk("rst_sram_we", SRAM_WE, 1'b0);
    chk("rst_sram_addr", SRAM_ADDR, '0);
    chk("rst_sram_din", SRAM_DIN, '0);
    RST_N  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // SET then ACC then READ on one address.
    issue(OP_SET, 5, rep(16'd10));
    idle(1);
    txn("t1_acc", OP_ACC, 5, rep(16'd3), rep(16'd13), 8'h00);
    chk("t1_latency", last_rsp_edge - acc_log[$], 2);
    txn("t1_read", OP_READ, 5, '0, rep(16'd13), 8'h00);
    idle(2);

    // Held REQ_VALID: SET then three ACC to the same address.
    n0 = rsp_seen;
    a0 = acc_log.size();
    issue(OP_SET, 7, rep(16'd10));
    issue(OP_ACC, 7, rep(16'd1));
    issue(OP_ACC, 7, rep(16'd1));
    issue(OP_ACC, 7, rep(16'd1));
    idle(6);
    if (rsp_log.size() >= n0 + 3 && acc_log.size() >= a0 + 4) begin
      chk("t2_rsp0", rsp_log[n0], rep(16'd11));
      chk("t2_rsp1", rsp_log[n0+1], rep(16'd12));
      chk("t2_rsp2", rsp_log[n0+2], rep(16'd13));
      chk("t2_gap_set_acc", acc_log[a0+1] - acc_log[a0], 1);
      chk("t2_gap_acc1", acc_log[a0+2] - acc_log[a0+1], 2);
      chk("t2_gap_acc2", acc_log[a0+3] - acc_log[a0+2], 2);
    end else chk_timeout("t2_responses");
    txn("t2_read", OP_READ, 7, '0, rep(16'd13), 8'h00);

    // Saturation in both directions on lanes 0 and 1.
    d = '0;
    d[15:0]  = 16'h7FFE;
    d[31:16] = 16'h8001;
    issue(OP_SET, 9, d);
    idle(1);
    d = '0;
    d[15:0]  = 16'h0005;
    d[31:16] = 16'hFFFC;
    e = '0;
    e[15:0]  = 16'h7FFF;
    e[31:16] = 16'h8000;
    txn("t3_acc_sat", OP_ACC, 9, d, e, 8'b0000_0011);

    // Full clear sweep.
    issue(OP_SET, 0, rep(16'h1234));
    issue(OP_SET, 255, rep(16'h5678));
    issue(OP_CLR, 0, '0);
    REQ_VALID = 1'b0;
    busy_cnt = 0;
    rdy_bad = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK);
      if (!BUSY) break;
      busy_cnt++;
      if (REQ_READY) rdy_bad++;
    end
    chk("t4_busy_cycles", busy_cnt, 256);
    chk("t4_ready_low", rdy_bad, 0);
    @(posedge CLK);
    #1;
    txn("t4_read0", OP_READ, 0, '0, '0, 8'h00);
    txn("t4_read255", OP_READ, 255, '0, '0, 8'h00);

    // Reset during the sweep at counter 100.
    issue(OP_SET, 99, rep(16'h1111));
    issue(OP_SET, 200, rep(16'h2222));
    issue(OP_CLR, 0, '0);
    REQ_VALID = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    chk("t5_busy", BUSY, 1'b0);
    chk("t5_cs", SRAM_CS, 1'b0);
    chk("t5_rsp_valid", RSP_VALID, 1'b0);
    txn("t5_read99", OP_READ, 99, '0, '0, 8'h00);
    txn("t5_read200", OP_READ, 200, '0, rep(16'h2222), 8'h00);

    // Random SET/ACC/READ mix with random gaps.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      int gap;
      int sv;
      op = 2'($urandom_range(0, 2));
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < LANES; i++) begin
          sv = $urandom_range(0, 15) - 8;
          d[i*LW +: LW] = sv[LW-1:0];
        end
      end
      issue(op, $urandom_range(16, 31), d);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    idle(6);

    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (sram_mem[a] !== ref_mem[a]) bad++;
    chk("final_mem_image", bad, 0);
    chk("final_rsp_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
